// File: rtl/key_loader_pkg.sv
// Shared types and helpers for the serial key loader.
package key_loader_pkg;

  localparam int MAX_KEY_WIDTH = 32;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, DONE} kl_state_t;

  // Zero-extension is harmless here: padding bits do not change the XOR.
  function automatic logic even_parity(input logic [MAX_KEY_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/key_loader_if.sv
// Key store / key loader signal bundle; master is the off-chip key store side.
interface key_loader_if #(
  parameter int KEY_WIDTH = 4
);
  logic                 load_start;
  logic                 key_sdata_in;
  logic                 key_sdata_valid;
  logic [KEY_WIDTH-1:0] key_out;
  logic                 key_ready;
  logic                 key_err;
  logic                 busy;

  modport master (
    output load_start, key_sdata_in, key_sdata_valid,
    input  key_out, key_ready, key_err, busy
  );

  modport slave (
    input  load_start, key_sdata_in, key_sdata_valid,
    output key_out, key_ready, key_err, busy
  );
endinterface

// File: rtl/key_shift_reg.sv
// Indexed shadow register and bit counter for the incoming key frame.
// Bits land LSB first; full rises once KEY_WIDTH data bits are held.
module key_shift_reg #(
  parameter  int KEY_WIDTH = 4,
  localparam int CNT_W     = $clog2(KEY_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 shift_en,
  input  logic                 sdata,
  output logic [KEY_WIDTH-1:0] shadow,
  output logic                 full
);

  logic [CNT_W-1:0] bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      shadow  <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      for (int i = 0; i < KEY_WIDTH; i++) begin
        if (bit_cnt == CNT_W'(i)) shadow[i] <= sdata;
      end
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign full = (bit_cnt == CNT_W'(KEY_WIDTH));

endmodule

// File: rtl/key_loader.sv
// Receives the unlock key serially, checks even parity, and commits it atomically
// to the locked core's key inputs; the core sees zeros until the first good frame.
module key_loader
  import key_loader_pkg::*;
#(
  parameter int KEY_WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  key_loader_if.slave  bus
);

  kl_state_t            state;
  logic [KEY_WIDTH-1:0] shadow;
  logic [KEY_WIDTH-1:0] key_out_q;
  logic                 full;
  logic                 parity_bit;
  logic                 key_ready_q;
  logic                 key_err_q;
  logic                 busy_q;
  logic                 clear;
  logic                 shift_en;

  // A start pulse restarts the frame from any state except CHECK, and beats a
  // data bit arriving on the same edge.
  assign clear    = bus.load_start && (state != CHECK);
  assign shift_en = (state == SHIFT) && !bus.load_start && bus.key_sdata_valid && !full;

  key_shift_reg #(.KEY_WIDTH(KEY_WIDTH)) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .shift_en (shift_en),
    .sdata    (bus.key_sdata_in),
    .shadow   (shadow),
    .full     (full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      parity_bit  <= 1'b0;
      key_out_q   <= '0;
      key_ready_q <= 1'b0;
      key_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.load_start) begin
            state     <= SHIFT;
            key_err_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        SHIFT: begin
          if (!bus.load_start && bus.key_sdata_valid && full) begin
            parity_bit <= bus.key_sdata_in;
            state      <= CHECK;
          end
        end
        CHECK: begin
          busy_q <= 1'b0;
          if (even_parity(MAX_KEY_WIDTH'(shadow)) == parity_bit) begin
            key_out_q   <= shadow;
            key_ready_q <= 1'b1;
            state       <= DONE;
          end else begin
            key_err_q <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.key_out   = key_out_q;
  assign bus.key_ready = key_ready_q;
  assign bus.key_err   = key_err_q;
  assign bus.busy      = busy_q;

endmodule
